// File: rtl/pipe_addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: stage count,
// parameter sanity helpers, the result-flag bundle and the overflow rule.
package pipe_addsub_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

    // Flags that leave the last stage alongside the sum.
    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } flags_t;

    // Number of carry-chained stages; never fewer than one.
    function automatic int calc_stages(input int width, input int chunk);
        int n;
        n = (chunk > 0) ? (width / chunk) : 1;
        return (n < 1) ? 1 : n;
    endfunction

    // A split is legal only if the chunks tile the word exactly.
    function automatic logic split_ok(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

    // Two's-complement overflow: carry into the MSB disagrees with carry out.
    function automatic logic signed_ovf(input logic c_into_msb, input logic c_out_msb);
        return c_into_msb ^ c_out_msb;
    endfunction

endpackage

// File: rtl/pipe_addsub_chunk_add.sv
// Combinational CHUNK-bit adder slice. Besides sum and carry-out it reports
// the carry into its own MSB so the top slice can derive signed overflow.
module chunk_add #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_ci,
    output logic [CHUNK-1:0] o_s,
    output logic             o_co,
    output logic             o_cmsb
);

    logic [CHUNK:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_ci};
    assign o_s    = w_full[CHUNK-1:0];
    assign o_co   = w_full[CHUNK];

    // The MSB sum bit is a ^ b ^ carry_in, so the carry into it falls out by XOR.
    assign o_cmsb = w_full[CHUNK-1] ^ i_a[CHUNK-1] ^ i_b[CHUNK-1];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined adder/subtractor. A WIDTH-bit operation is split into
// WIDTH/CHUNK slices, one per stage, with the inter-slice carry registered.
// Operands not yet consumed ride forward in skew registers; resolved sum
// chunks accumulate in deskew registers so a beat leaves in one piece.
// A single global stall (result valid but not taken) freezes every stage.
module pipe_addsub
    import pipe_addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    if (!split_ok(WIDTH, CHUNK)) begin : gen_bad_split
        $error("pipe_addsub: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)",
               WIDTH, CHUNK);
    end

    logic             w_stall;
    logic             w_adv;
    logic [WIDTH-1:0] w_bb;
    logic             w_c0;

    // Subtract is A + ~B + ~cin, i.e. A - B - cin with borrow folded into the carry.
    assign w_bb = sub ? ~b : b;
    assign w_c0 = sub ? ~cin : cin;

    // Stall only when a finished beat is waiting; bubbles never block.
    assign w_stall  = gen_stage[STAGES-1].r_valid & ~out_ready;
    assign w_adv    = ~w_stall;
    assign in_ready = w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : gen_stage
        localparam int LO  = k * CHUNK;        // first operand bit handled here
        localparam int UPW = WIDTH - LO;       // operand bits still unprocessed
        localparam int SW  = (k + 1) * CHUNK;  // sum bits resolved after this stage

        logic [UPW-1:0]   w_a_up;
        logic [UPW-1:0]   w_b_up;
        logic             w_ci;
        logic             w_vin;
        logic [CHUNK-1:0] w_s;
        logic             w_co;
        logic             w_cmsb;
        logic [SW-1:0]    w_sum_nx;

        logic             r_valid;
        logic [SW-1:0]    r_sum;

        if (k == 0) begin : gen_head
            assign w_a_up   = a;
            assign w_b_up   = w_bb;
            assign w_ci     = w_c0;
            assign w_vin    = in_valid;
            assign w_sum_nx = w_s;
        end else begin : gen_link
            assign w_a_up   = gen_stage[k-1].gen_fwd.r_a_skew;
            assign w_b_up   = gen_stage[k-1].gen_fwd.r_b_skew;
            assign w_ci     = gen_stage[k-1].gen_fwd.r_carry;
            assign w_vin    = gen_stage[k-1].r_valid;
            assign w_sum_nx = {w_s, gen_stage[k-1].r_sum};
        end

        chunk_add #(
            .CHUNK (CHUNK)
        ) u_chunk_add (
            .i_a    (w_a_up[CHUNK-1:0]),
            .i_b    (w_b_up[CHUNK-1:0]),
            .i_ci   (w_ci),
            .o_s    (w_s),
            .o_co   (w_co),
            .o_cmsb (w_cmsb)
        );

        // Advance the slot's valid and resolved sum chunks; hold while stalled.
        always_ff @(posedge clk or negedge rst_n) begin
            // NOTE: non-blocking assignments so every stage samples the
            // pre-edge value of its neighbour; blocking would collapse stages.
            // NOTE: data is reset along with valid so no stale value is ever
            // visible on the outputs, even with out_valid low.
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_sum   <= '0;
            end else if (w_adv) begin
                r_valid <= w_vin;
                r_sum   <= w_sum_nx;
            end
        end

        if (k < STAGES - 1) begin : gen_fwd
            logic [UPW-CHUNK-1:0] r_a_skew;
            logic [UPW-CHUNK-1:0] r_b_skew;
            logic                 r_carry;
            logic                 w_unused_cmsb;

            // Only the top slice needs the carry into its MSB.
            assign w_unused_cmsb = w_cmsb;

            // Carry and untouched upper operand chunks move one stage on.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a_skew <= '0;
                    r_b_skew <= '0;
                    r_carry  <= 1'b0;
                end else if (w_adv) begin
                    r_a_skew <= w_a_up[UPW-1:CHUNK];
                    r_b_skew <= w_b_up[UPW-1:CHUNK];
                    r_carry  <= w_co;
                end
            end
        end else begin : gen_tail
            flags_t r_flags;

            // Final carry, overflow and zero detect registered with the sum.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_flags <= '0;
                end else if (w_adv) begin
                    r_flags.cout <= w_co;
                    r_flags.ovf  <= signed_ovf(w_cmsb, w_co);
                    r_flags.zero <= ~|w_sum_nx;
                end
            end
        end
    end

    assign out_valid = gen_stage[STAGES-1].r_valid;
    assign sum       = gen_stage[STAGES-1].r_sum;
    assign cout      = gen_stage[STAGES-1].gen_tail.r_flags.cout;
    assign ovf       = gen_stage[STAGES-1].gen_tail.r_flags.ovf;
    assign zero      = gen_stage[STAGES-1].gen_tail.r_flags.zero;

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub (WIDTH=32, CHUNK=8, latency 4).
// Drivers push expected results into a scoreboard queue when a beat is
// accepted; a negedge monitor pops and compares whenever a result is taken.
module tb_pipe_addsub;

    localparam int W   = 32;
    localparam int C   = 8;
    localparam int LAT = W / C;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    typedef struct {
        res_t res;
        int   cyc;
    } sb_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    sb_t sb_q[$];
    sb_t sb_e;
    int  tests_run    = 0;
    int  tests_failed = 0;
    int  cyc          = 0;
    int  pops         = 0;
    bit  chk_lat      = 1'b1;

    pipe_addsub #(
        .WIDTH (W),
        .CHUNK (C)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model built from plain wide arithmetic.
    function automatic res_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                   input logic tcin, input logic tsub);
        res_t         r;
        logic [W:0]   u;
        longint       sa, sb, sr;
        sa = longint'($signed(ta));
        sb = longint'($signed(tb));
        if (tsub) begin
            u      = {1'b0, ta} - {1'b0, tb} - {{W{1'b0}}, tcin};
            r.cout = ~u[W];
            sr     = sa - sb - longint'(tcin);
        end else begin
            u      = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tcin};
            r.cout = u[W];
            sr     = sa + sb + longint'(tcin);
        end
        r.sum  = u[W-1:0];
        r.zero = (u[W-1:0] == '0);
        r.ovf  = (sr != longint'($signed(u[W-1:0])));
        return r;
    endfunction

    function automatic res_t mk(input logic [W-1:0] s, input logic c,
                                input logic o, input logic z);
        return {s, c, o, z};
    endfunction

    // Scoreboard consumer: every taken result must match the oldest pending beat.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            tests_run++;
            if (sb_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_result: got sum=%h cout=%b ovf=%b zero=%b, no beat pending",
                         sum, cout, ovf, zero);
            end else begin
                sb_e = sb_q.pop_front();
                if ({sum, cout, ovf, zero} !== sb_e.res) begin
                    tests_failed++;
                    $display("FAIL result: got sum=%h cout=%b ovf=%b zero=%b, want sum=%h cout=%b ovf=%b zero=%b",
                             sum, cout, ovf, zero, sb_e.res.sum, sb_e.res.cout,
                             sb_e.res.ovf, sb_e.res.zero);
                end
                if (chk_lat) begin
                    tests_run++;
                    if (cyc - sb_e.cyc != LAT) begin
                        tests_failed++;
                        $display("FAIL latency: got %0d cycles, want %0d", cyc - sb_e.cyc, LAT);
                    end
                end
            end
            pops++;
        end
    end

    // Present one beat, hold it until accepted, record the expected result.
    task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tcin, input logic tsub, input res_t exp);
        bit acc;
        int waitc;
        a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
        acc = 1'b0;
        waitc = 0;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) sb_q.push_back('{res: exp, cyc: cyc});
            @(posedge clk);
            #1;
            if (!acc) begin
                waitc++;
                if (waitc > 50) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL accept_timeout: in_ready=%b after %0d cycles, want 1", in_ready, waitc);
                    break;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tcin, input logic tsub);
        drive(ta, tb, tcin, tsub, model(ta, tb, tcin, tsub));
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d beats still pending, want 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, sum, cout, ovf, zero} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b ovf=%b zero=%b, want all 0",
                     out_valid, sum, cout, ovf, zero);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL after_reset: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        chk_lat = 1'b1;
        drive(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h0000_0100, 1'b0, 1'b0, 1'b0));
        wait_drain(20);
        drive(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1));
        wait_drain(20);
        drive(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
        wait_drain(20);
        drive(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
        wait_drain(20);
        drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0));
        wait_drain(20);
        drive(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, mk(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0));
        wait_drain(20);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] edge_v [4];
        logic [W-1:0] ta, tb;
        int p0;
        edge_v[0] = 32'h0000_0000;
        edge_v[1] = 32'hFFFF_FFFF;
        edge_v[2] = 32'h8000_0000;
        edge_v[3] = 32'h7FFF_FFFF;
        chk_lat = 1'b1;
        p0 = pops;
        for (int i = 0; i < 20; i++) begin
            ta = (i % 4 == 0) ? edge_v[i/4 % 4] : $urandom;
            tb = (i % 5 == 0) ? edge_v[(i/5 + 1) % 4] : $urandom;
            send(ta, tb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        wait_drain(40);
        tests_run++;
        if (pops - p0 != 20) begin
            tests_failed++;
            $display("FAIL stream_count: got %0d results, want 20", pops - p0);
        end
    endtask

    task automatic test_backpressure();
        res_t snap;
        int   p0;
        chk_lat = 1'b0;
        p0 = pops;
        fork
            begin
                for (int i = 0; i < 12; i++)
                    send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                snap = {sum, cout, ovf, zero};
                tests_run++;
                if (out_valid !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL stall_valid: got out_valid=%b, want 1", out_valid);
                end
                for (int s = 0; s < 3; s++) begin
                    if (s > 0) @(negedge clk);
                    tests_run++;
                    if (in_ready !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL stall_in_ready: cycle %0d got %b, want 0", s, in_ready);
                    end
                    tests_run++;
                    if ({sum, cout, ovf, zero} !== snap || out_valid !== 1'b1) begin
                        tests_failed++;
                        $display("FAIL stall_frozen: cycle %0d got sum=%h valid=%b, want sum=%h valid=1",
                                 s, sum, out_valid, snap.sum);
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(negedge clk);
                tests_run++;
                if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL release: got in_ready=%b out_valid=%b, want 1/1", in_ready, out_valid);
                end
            end
        join
        wait_drain(40);
        tests_run++;
        if (pops - p0 != 12) begin
            tests_failed++;
            $display("FAIL bp_count: got %0d results, want 12", pops - p0);
        end
        chk_lat = 1'b1;
    endtask

    task automatic test_reset_midflight();
        int stale;
        chk_lat = 1'b1;
        for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0, 1'(i & 1));
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_valid: got %b, want 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, sum, cout, ovf, zero} !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: got valid=%b sum=%h cout=%b ovf=%b zero=%b, want all 0",
                     out_valid, sum, cout, ovf, zero);
        end
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        tests_run++;
        if (stale != 0) begin
            tests_failed++;
            $display("FAIL stale_after_reset: out_valid high on %0d cycles, want 0", stale);
        end
        @(posedge clk);
        #1;
        drive(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, mk(32'h2345_678A, 1'b0, 1'b0, 1'b0));
        wait_drain(20);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_addsub.md
Name: pipe_addsub

Overview:
- Parametrised, pipelined adder/subtractor. It splits a WIDTH-bit operation into WIDTH/CHUNK carry-chained stages and registers the carry between stages.
- Adds subtract mode, signed-overflow and zero flags, and a valid/ready handshake with backpressure.
- Sits in the datapath wherever wide sums must close timing at full clock rate.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits resolved per pipeline stage; STAGES = WIDTH/CHUNK, minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A (unsigned or two's complement).
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0: A+B+cin; 1: A-B-cin.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  add: carry-out; sub: NOT borrow (1 = no borrow).
- ovf  out  1  signed two's-complement overflow.
- zero  out  1  sum == 0.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n). Reset clears all stage valids and data.
  - Reset values: out_valid=0, sum=0, cout=0, ovf=0, zero=0.
  - in_ready=1 after reset deasserts.
- Operand conditioning at entry:
  - bb = sub ? ~b : b.
  - c0 = sub ? ~cin : cin.
  - So sub computes A + ~B + ~cin = A - B - cin.
- Stage k (k=0..STAGES-1):
  - Adds chunk k of a and bb with the carry from stage k-1 (stage 0 uses c0).
  - Registers the chunk sum and carry-out.
  - Forwards the not-yet-processed upper chunks of a/bb through skew registers.
  - Passes the already-computed lower sum chunks through deskew registers, so all chunks of a beat exit together.
- Latency: a beat accepted on cycle t appears with out_valid=1 on cycle t+STAGES when there is no stall. Throughput is 1 beat/cycle.
- Handshake:
  - Input accepted when in_valid && in_ready.
  - Output consumed when out_valid && out_ready.
  - Global stall = out_valid && !out_ready. While stalled, every stage register holds and in_ready=0 (combinational from out_ready).
  - No bubble collapsing; empty slots travel as valid=0.
  - in_valid while in_ready=0 is ignored (not latched); the producer must hold.
  - out_valid, sum, cout, ovf and zero are stable while stalled.
- Flags, computed in the last stage from MSB-chunk data:
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = ~|sum.
  - cout = final carry.
- Boundary conditions:
  - STAGES=1 degenerates to a single registered adder with latency 1.
  - Pipeline full and stalled, then out_ready rises: the oldest beat drains and a new beat is accepted on the same edge.
  - Reset mid-operation: in-flight beats are discarded; no partial result is ever presented.

Decomposition:
- Shared package, pipe_addsub_pkg:
  - localparam helper for STAGES.
  - function for signed-overflow detection.
  - Elaboration check: WIDTH % CHUNK == 0, else $error.
- One sub-module, chunk_add: combinational CHUNK-bit adder (a, b, ci → s, co, plus carry into its MSB for the ovf calculation). Instantiated STAGES times in a generate loop.

Test Plan (WIDTH=32, CHUNK=8, latency 4):
- Reset then single add: a=0x0000_00FF, b=0x0000_0001, cin=0, sub=0 → 4 cycles later sum=0x0000_0100, cout=0, ovf=0, zero=0. Exercises carry across the chunk 0→1 boundary.
- Full carry ripple: a=0xFFFF_FFFF, b=0, cin=1 → sum=0, cout=1, zero=1, ovf=0.
- Subtract and overflow:
  - a=5, b=7, sub=1, cin=0 → sum=0xFFFF_FFFE, cout=0 (borrow).
  - a=0x8000_0000, b=1, sub=1 → sum=0x7FFF_FFFF, ovf=1, cout=1.
- Streaming: 20 back-to-back random beats with out_ready=1 → results match the reference model, one per cycle, in order, first at cycle 4.
- Backpressure: stream beats and drop out_ready for 3 cycles mid-stream:
  - in_ready=0 and outputs frozen during the stall.
  - No beat lost or duplicated.
  - Order preserved after release.
- Reset mid-flight: accept 3 beats, assert rst_n=0 asynchronously between edges → out_valid drops to 0 immediately. After release, no stale results appear and the next beat returns in 4 cycles.
